// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared types and constants for the linear-mode CORDIC scheduler.
//   DATA_W        : default data width W (signed Q1.15)
//   op_t          : operation kind carried with every issued request
//   sched_state_t : scheduler FSM states
//   tag_t         : per-operation tag that travels alongside the core latency
//   Q_ONE / Q_SAT_POS / Q_SAT_NEG : Q1.15 constants for saturated quotients
//   abs_ext()     : magnitude of a signed W-bit value in W+1 bits
// -----------------------------------------------------------------------------
package cordic_pkg;

  localparam int DATA_W = 16;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } sched_state_t;

  // neg records whether the divide operands had different signs, so an
  // overflowed quotient can saturate in the right direction without needing
  // any core output.
  typedef struct packed {
    logic valid;
    op_t  op;
    logic ovf;
    logic neg;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  localparam logic [DATA_W-1:0] Q_ONE     = 16'd32767;
  localparam logic [DATA_W-1:0] Q_SAT_POS = Q_ONE;
  localparam logic [DATA_W-1:0] Q_SAT_NEG = 16'h8001;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, op: OP_MUL, ovf: 1'b0, neg: 1'b0};

  // One extra bit so that the most negative value (-32768) has a
  // representable magnitude.
  function automatic logic [DATA_W:0] abs_ext(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] ext;
    ext = {v[DATA_W-1], v};
    if (v[DATA_W-1]) begin
      abs_ext = (~ext) + {{DATA_W{1'b0}}, 1'b1};
    end else begin
      abs_ext = ext;
    end
  endfunction

endpackage

// File: rtl/cordic_line_sched_tag_delay_line.sv
// -----------------------------------------------------------------------------
// tag_delay_line
// Fixed-depth shift register that carries operation tags in lock-step with
// the core pipeline. Advances every cycle; cleared by reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : tag entering stage 0
//   dout       : tag leaving the last stage
//   any_valid  : OR of the VALID_BIT of every stage (work still in flight)
// -----------------------------------------------------------------------------
module tag_delay_line #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 4,
  parameter int VALID_BIT = WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             any_valid
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift the tag pipe by one stage per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // Collect the valid flags of all stages.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | stage_r[i][VALID_BIT];
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/cordic_line_sched.sv
// -----------------------------------------------------------------------------
// cordic_line_sched
// Shares one linear-mode CORDIC core between a multiply and a divide
// requester. Round-robin arbitration, one issue per cycle, tagged results.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   mul_valid/mul_ready/mul_x/y   : multiply request (x*y)
//   div_valid/div_ready/num/den   : divide request (num/den)
//   mul_res_valid, mul_res        : product pulse
//   div_res_valid, div_res,div_ovf: quotient pulse, ovf qualifies it
//   core_en, core_a/b/c           : registered core operation
//   core_res, core_error,core_done: core y-path, z-path, result strobe
//   busy                          : flushing or operations in flight
//   sync_err                      : sticky core_done / tag mismatch flag
// Core convention: multiply a=x,b=0,c=y -> core_res;
//                  divide   a=den,b=num,c=0 -> core_error.
// -----------------------------------------------------------------------------
module cordic_line_sched
  import cordic_pkg::*;
#(
  parameter int W       = cordic_pkg::DATA_W,
  parameter int LATENCY = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mul_valid,
  output logic         mul_ready,
  input  logic [W-1:0] mul_x,
  input  logic [W-1:0] mul_y,
  input  logic         div_valid,
  output logic         div_ready,
  input  logic [W-1:0] div_num,
  input  logic [W-1:0] div_den,
  output logic         mul_res_valid,
  output logic [W-1:0] mul_res,
  output logic         div_res_valid,
  output logic [W-1:0] div_res,
  output logic         div_ovf,
  output logic         core_en,
  output logic [W-1:0] core_a,
  output logic [W-1:0] core_b,
  output logic [W-1:0] core_c,
  input  logic [W-1:0] core_res,
  input  logic [W-1:0] core_error,
  input  logic         core_done,
  output logic         busy,
  output logic         sync_err
);

  localparam int               CNT_W      = $clog2(LATENCY + 2);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(LATENCY);

  sched_state_t     state_r;
  logic [CNT_W-1:0] flush_cnt_r;
  op_t              rr_r;

  logic             grant_mul_s;
  logic             grant_div_s;
  logic [W:0]       num_abs_s;
  logic [W:0]       den_abs_s;
  logic             range_ovf_s;
  logic             sign_diff_s;

  logic             issue_en_s;
  logic [W-1:0]     issue_a_s;
  logic [W-1:0]     issue_b_s;
  logic [W-1:0]     issue_c_s;
  tag_t             issue_tag_s;
  tag_t             issue_tag_r;

  logic [TAG_W-1:0] tag_out_s;
  tag_t             out_tag_s;
  logic             pipe_busy_s;

  // Scheduler FSM: hold off for LATENCY+1 cycles after reset so any result
  // the unreset core still emits from before the reset is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_FLUSH;
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_FLUSH: begin
          if (flush_cnt_r == FLUSH_LAST) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= {CNT_W{1'b0}};
          end else begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          state_r     <= ST_RUN;
          flush_cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          state_r     <= ST_FLUSH;
          flush_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Arbiter: a lone request wins; on contention the rr pointer decides.
  always_comb begin
    grant_mul_s = 1'b0;
    grant_div_s = 1'b0;
    if (state_r == ST_RUN) begin
      if (mul_valid && div_valid) begin
        if (rr_r == OP_MUL) begin
          grant_mul_s = 1'b1;
        end else begin
          grant_div_s = 1'b1;
        end
      end else begin
        grant_mul_s = mul_valid;
        grant_div_s = div_valid;
      end
    end else begin
      grant_mul_s = 1'b0;
      grant_div_s = 1'b0;
    end
  end

  assign mul_ready = grant_mul_s;
  assign div_ready = grant_div_s;

  // Divide range check: a Q1.15 quotient only exists for |num| < |den|.
  always_comb begin
    num_abs_s   = abs_ext(div_num);
    den_abs_s   = abs_ext(div_den);
    sign_diff_s = div_num[W-1] ^ div_den[W-1];
    range_ovf_s = (div_den == {W{1'b0}}) || (num_abs_s >= den_abs_s);
  end

  // Build the next core operation and its tag from the grant.
  always_comb begin
    issue_en_s  = 1'b0;
    issue_a_s   = {W{1'b0}};
    issue_b_s   = {W{1'b0}};
    issue_c_s   = {W{1'b0}};
    issue_tag_s = TAG_IDLE;
    case ({grant_div_s, grant_mul_s})
      2'b01: begin
        issue_en_s        = 1'b1;
        issue_a_s         = mul_x;
        issue_c_s         = mul_y;
        issue_tag_s.valid = 1'b1;
        issue_tag_s.op    = OP_MUL;
      end
      2'b10: begin
        // Overflowing divides are still issued to keep core timing uniform.
        issue_en_s        = 1'b1;
        issue_a_s         = div_den;
        issue_b_s         = div_num;
        issue_tag_s.valid = 1'b1;
        issue_tag_s.op    = OP_DIV;
        issue_tag_s.ovf   = range_ovf_s;
        issue_tag_s.neg   = sign_diff_s;
      end
      default: begin
        issue_en_s  = 1'b0;
        issue_tag_s = TAG_IDLE;
      end
    endcase
  end

  // Issue register: core strobe, operands, the matching tag and rr pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_en     <= 1'b0;
      core_a      <= {W{1'b0}};
      core_b      <= {W{1'b0}};
      core_c      <= {W{1'b0}};
      issue_tag_r <= TAG_IDLE;
      rr_r        <= OP_MUL;
    end else begin
      core_en     <= issue_en_s;
      core_a      <= issue_a_s;
      core_b      <= issue_b_s;
      core_c      <= issue_c_s;
      issue_tag_r <= issue_tag_s;
      if ((state_r == ST_RUN) && mul_valid && div_valid) begin
        rr_r <= grant_mul_s ? OP_DIV : OP_MUL;
      end else begin
        rr_r <= rr_r;
      end
    end
  end

  // The issue register already accounts for the cycle core_en is visible,
  // so LATENCY stages line the tag up with the matching core_done.
  tag_delay_line #(
    .DEPTH     (LATENCY),
    .WIDTH     (TAG_W),
    .VALID_BIT (TAG_W - 1)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (issue_tag_r),
    .dout      (tag_out_s),
    .any_valid (pipe_busy_s)
  );

  assign out_tag_s = tag_t'(tag_out_s);
  assign busy      = (state_r == ST_FLUSH) || issue_tag_r.valid || pipe_busy_s;

  // Result routing and mismatch detection; result pulses last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_res_valid <= 1'b0;
      mul_res       <= {W{1'b0}};
      div_res_valid <= 1'b0;
      div_res       <= {W{1'b0}};
      div_ovf       <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      mul_res_valid <= 1'b0;
      div_res_valid <= 1'b0;
      div_ovf       <= 1'b0;
      if (state_r == ST_RUN) begin
        if (out_tag_s.valid && core_done) begin
          case (out_tag_s.op)
            OP_MUL: begin
              mul_res_valid <= 1'b1;
              mul_res       <= core_res;
            end
            OP_DIV: begin
              div_res_valid <= 1'b1;
              div_ovf       <= out_tag_s.ovf;
              if (out_tag_s.ovf) begin
                div_res <= out_tag_s.neg ? Q_SAT_NEG : Q_SAT_POS;
              end else begin
                div_res <= core_error;
              end
            end
            default: begin
              sync_err <= 1'b1;
            end
          endcase
        end else if (out_tag_s.valid || core_done) begin
          // Tag and strobe disagree: drop the result, keep the pipe moving.
          sync_err <= 1'b1;
        end else begin
          sync_err <= sync_err;
        end
      end else begin
        sync_err <= sync_err;
      end
    end
  end

endmodule

// File: doc/cordic_line_sched.md
# cordic_line_sched

Scheduler that shares one `cordic_line_mode` linear-mode CORDIC core between a multiply requester and a divide requester. It arbitrates round-robin and drives the core's `en/a/b/c` inputs one operation per cycle. Issued operations are tagged so that each `done` result goes back to the right requester. It sits between the DSP control logic and the core, and it is the only block that drives the core.

## Interface
Parameters:
- `W`, 16: data width, signed Q1.15.
- `LATENCY`, 16: core cycles from `en` sample to matching `done` (fixed by core build).

Ports:
- `clk` in 1: clock. The block uses this one clock only.
- `rst_n` in 1: reset, asynchronous and active-low.
- `mul_valid` in 1: multiply request valid.
- `mul_ready` out 1: multiply request accepted this cycle.
- `mul_x` in W: multiplicand, goes to core `a`.
- `mul_y` in W: multiplier, goes to core `c`.
- `div_valid` in 1: divide request valid.
- `div_ready` out 1: divide request accepted this cycle.
- `div_num` in W: dividend, goes to core `b`.
- `div_den` in W: divisor, goes to core `a`.
- `mul_res_valid` out 1: one-cycle pulse, product ready.
- `mul_res` out W: product x·y.
- `div_res_valid` out 1: one-cycle pulse, quotient ready.
- `div_res` out W: quotient num/den.
- `div_ovf` out 1: qualifies `div_res_valid`; set when |num| ≥ |den| or den = 0.
- `core_en` out 1: core operation strobe.
- `core_a` out W: core operand `a`.
- `core_b` out W: core operand `b`.
- `core_c` out W: core operand `c`.
- `core_res` in W: core y-path output.
- `core_error` in W: core z-path output.
- `core_done` in 1: core result strobe.
- `busy` out 1: operations in flight, or flush in progress.
- `sync_err` out 1: sticky; set on any mismatch between `core_done` and the tag pipe.

## Operation
- Core convention:
  - Multiply is `a=x, b=0, c=y`; the result is on `core_res`.
  - Divide is `a=den, b=num, c=0`; the result is on `core_error`.
- FSM states:
  - **FLUSH** (entered on reset): readies held 0. A counter runs LATENCY+1 cycles, and `core_done` is ignored during this time, because the core has no reset and may still emit results from before the reset. Then go to RUN.
  - **RUN**: normal operation.
- Arbitration in RUN:
  - A single valid request is granted.
  - When both are valid, grant the side named by the rr pointer, then point the pointer at the other side. The pointer resets to MUL.
  - Ready may depend on both valids. A requester's valid must not depend on its ready.
- Issue:
  - On a grant, the operands are registered onto `core_*` and `core_en`=1 for the next cycle.
  - With no grant, `core_en`=0 and all `core_a/b/c`=0.
- Divide range check: at acceptance, compute `ovf` = (den = 0) or (|num| ≥ |den|). The operation is still issued, so the core timing stays uniform.
- Tag pipe: a shift register LATENCY deep, each entry {valid, op, ovf}. It advances every cycle, and entry 0 is loaded from the issue.
- Result routing: when the tag at the output is valid and `core_done`=1:
  - A MUL tag pulses `mul_res_valid` with `mul_res` = `core_res`.
  - A DIV tag pulses `div_res_valid` with `div_res` = `core_error`, or 0x7FFF (0x8001 when signs differ) if ovf. `div_ovf` = ovf.
- Mismatch: a valid tag without `core_done`, or `core_done` without a valid tag (in RUN), sets `sync_err`. The result is dropped and the pipe keeps advancing. `sync_err` clears only on reset.
- Abs arithmetic uses W+1 bits so that −32768 does not overflow.

## Timing
- Request accepted at edge N:
  - `core_en` high during cycle N+1.
  - `core_done` is expected in cycle N+1+LATENCY.
  - The result valid is registered and pulses in cycle N+2+LATENCY.
  - Total latency is LATENCY+2.
- Throughput: one operation per cycle, in total across both requesters. Results leave in issue order.
- Reset values: all readies 0, `core_en` 0, `core_a/b/c` 0, all result outputs 0, `div_ovf` 0, `sync_err` 0, `busy` 1 (FLUSH).
- `busy` = FLUSH, or any tag valid.
- Reset mid-operation: all tags are cleared and nothing in flight is delivered. FLUSH blocks the stale `core_done` pulses that follow.
- Results have no backpressure. Consumers must always be able to take a pulse.

## Structure
- Shared package `cordic_pkg` holds:
  - `W`;
  - the op enum {OP_MUL, OP_DIV};
  - the tag struct;
  - the Q1.15 constants (0x7FFF, 0x8001, one = 32767).
- The tag pipe is one sub-module, `tag_delay_line` (parameters: depth, width). Arbiter, FSM and routing stay in the top level.
- The bench instantiates the real `cordic_line_mode` with `LATENCY` matched to the core.

## Test plan
- Single multiply, x=26213 (0.8) and y=19660 (0.6) → `mul_res` ≈ 15728 (±4 LSB) exactly LATENCY+2 cycles after acceptance.
- Single divide, num=19660 (0.6) and den=26213 (0.8) → `div_res` ≈ 24575 (0.75) ±4, `div_ovf`=0.
- Both valid every cycle for 8 cycles → grants alternate MUL, DIV, …, starting MUL. Results come out in the same order and each goes to the correct port.
- Divide with num=22936 (0.7) and den=19660 (0.6) → `div_ovf`=1, `div_res`=0x7FFF. A following legal divide is unaffected.
- Assert `rst_n` low for 1 cycle with 5 operations in flight → no result pulses, readies 0 for LATENCY+1 cycles, `sync_err` stays 0, then a new multiply completes correctly.
- Bench injects a spurious `core_done` in RUN → `sync_err` goes to 1 and stays there, no result pulse.
